ad1868_i2s_sequencer: RTL and testbench
=======================================

// Module: ad1868_i2s_sequencer
// PURPOSE
//  Timing controller for the AD1868->I2S bridge: one instance drives two sample-latch channels (L, R).
//  Samples the AD1868-side BCK/LL/LR pins and emits the per-bit shift and per-channel capture strobes.
//  Generates I2S BCK/LRCK and the frame-aligned transfer strobe.
//  Tracks sample freshness and reports dropped and repeated samples.
// PARAMETERS
//  DIV_BCK      4   i_clk cycles per BCK half-period (>=2)
//  BITS         32  BCK periods per I2S channel slot (>=18)
//  SYNC_STAGES  2   synchroniser depth for AD-side pins (>=2)
// PORTS
//  i_clk          in   1  system clock; all logic on rising edge
//  i_rst          in   1  synchronous, active-high reset
//  i_en           in   1  I2S-side enable
//  i_ad_bck       in   1  AD1868 bit clock (async)
//  i_ad_ll        in   1  AD1868 left latch (async)
//  i_ad_lr        in   1  AD1868 right latch (async)
//  o_ad_shift     out  1  1-cycle pulse per AD BCK rising edge -> i_data shift enable
//  o_ad_latch_l   out  1  1-cycle pulse, capture left shift reg
//  o_ad_latch_r   out  1  1-cycle pulse, capture right shift reg
//  o_i2s_latch    out  1  1-cycle pulse, transfer captured L+R to output regs
//  o_i2s_bck      out  1  I2S bit clock
//  o_i2s_lrck     out  1  I2S word select (0=left)
//  o_drop         out  1  1-cycle pulse: captured sample overwritten before transfer
//  o_repeat       out  1  1-cycle pulse: frame boundary without complete fresh pair
//  o_locked       out  1  level: stream healthy
// BEHAVIOUR
//  Reset: all outputs 0.
//   Reset state: sync/history flops 0, prescaler 0, bit_cnt 0, pend_l/pend_r 0, good_cnt 0.
//  AD side (always active, independent of i_en):
//   - Each pin passes through SYNC_STAGES flops plus a history flop.
//   - A rising edge is synced & ~history.
//   - Strobe latency: SYNC_STAGES+1 cycles from pin edge.
//   - All AD edge pulses are suppressed for SYNC_STAGES+1 cycles after reset release.
//   - BCK rise -> o_ad_shift.
//   - LL rise -> o_ad_latch_l; LR rise -> o_ad_latch_r.
//   - Strobes may coincide with each other and with o_ad_shift; all are issued in the same cycle.
//  Freshness:
//   - Latch_l sets pend_l; latch_r sets pend_r.
//   - Latch_x while pend_x=1 (and not consumed in the same cycle) -> o_drop pulse; pend_x stays 1.
//  I2S generator (runs while i_en=1):
//   - Prescaler 0..DIV_BCK-1; at terminal count, toggle bck and wrap.
//   - bit_cnt 0..2*BITS-1 advances on each bck 1->0 toggle; wraps 2*BITS-1 -> 0.
//   - o_i2s_lrck = 1 iff bit_cnt in [BITS-1, 2*BITS-2]. This gives a one-bit lead per I2S.
//   - BCK period = 2*DIV_BCK cycles; frame = 4*DIV_BCK*BITS cycles.
//  Frame boundary (the cycle bit_cnt wraps to 0):
//   - Case pend_l&pend_r: o_i2s_latch pulses; both pend flags clear.
//   - Otherwise: no o_i2s_latch; o_repeat pulses; pend flags keep their value.
//   - Latch_x in the same cycle as a consume: pend_x ends at 1, no drop.
//  o_locked:
//   - good_cnt increments on each o_i2s_latch, saturating at 2; o_locked = (good_cnt==2).
//   - o_drop or o_repeat clears good_cnt and o_locked in the next cycle.
//   - If o_drop/o_repeat coincides with o_i2s_latch, the clear wins.
//  i_en=0:
//   - Prescaler and bit_cnt held at 0; bck and lrck are 0.
//   - No o_i2s_latch/o_repeat; pend flags and good_cnt cleared; o_drop is masked.
//   - On i_en 0->1, counting starts from prescaler=0, bit_cnt=0.
//     The first boundary occurs one full frame later.
//  Reset mid-operation: all state returns to reset values on the next edge; no partial strobes.
// TESTING (DIV_BCK=4, BITS=32, SYNC_STAGES=2)
//  1. Reset, i_en=1, no AD activity:
//     -> bck toggles every 4 cycles; lrck rises at bit_cnt 31 and falls at 63.
//     -> o_repeat every 512 cycles; o_locked=0.
//  2. Toggle i_ad_bck at period 10:
//     -> one o_ad_shift per rising edge, 3 cycles after the edge; none in the 3 cycles after reset.
//  3. LL then LR pulses once per frame, each before the boundary:
//     -> o_i2s_latch at each boundary; o_locked=1 after the 2nd latch; no drop/repeat.
//  4. Two LL pulses before one boundary:
//     -> o_drop on the 2nd LL; the next boundary still latches if LR arrived.
//  5. LL only (no LR) across a boundary:
//     -> o_repeat, no o_i2s_latch, o_locked falls the next cycle.
//  6. LL edge timed to land on the boundary cycle with pend_l=1, pend_r=1:
//     -> o_i2s_latch, pend_l=1 after, no o_drop.
//  7. Deassert i_en mid-frame:
//     -> bck/lrck go 0 next cycle; re-enable gives the first boundary 512 cycles later.

Source files
------------

// File: rtl/ad1868_i2s_sequencer.sv
// AD1868 -> I2S bridge timing controller: synchronises the AD-side BCK/LL/LR pins into
// strobes, generates I2S BCK/LRCK and tracks L/R sample freshness across frame boundaries.
module ad1868_i2s_sequencer #(
  parameter int DIV_BCK     = 4,
  parameter int BITS        = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_en,
  input  logic i_ad_bck,
  input  logic i_ad_ll,
  input  logic i_ad_lr,
  output logic o_ad_shift,
  output logic o_ad_latch_l,
  output logic o_ad_latch_r,
  output logic o_i2s_latch,
  output logic o_i2s_bck,
  output logic o_i2s_lrck,
  output logic o_drop,
  output logic o_repeat,
  output logic o_locked
);

  localparam int PW = (DIV_BCK > 1) ? $clog2(DIV_BCK) : 1;
  localparam int BW = $clog2(2 * BITS);
  localparam int IW = $clog2(SYNC_STAGES + 2);
  localparam logic [PW-1:0] PRESC_TC  = PW'(DIV_BCK - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(2 * BITS - 1);
  localparam logic [BW-1:0] LR_LO     = BW'(BITS - 1);
  localparam logic [BW-1:0] LR_HI     = BW'(2 * BITS - 2);
  localparam logic [IW-1:0] INIT_DONE = IW'(SYNC_STAGES + 1);

  // Pin bit order in the synchroniser and strobe vectors: {lr, ll, bck}
  logic [SYNC_STAGES-1:0][2:0] sync_q, sync_d;
  logic [2:0]    hist_q, hist_d;
  logic [2:0]    strobe_q, strobe_d;
  logic [IW-1:0] init_q, init_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          bck_q, bck_d;
  logic [BW-1:0] bit_q, bit_d;
  logic          pend_l_q, pend_l_d;
  logic          pend_r_q, pend_r_d;
  logic [1:0]    good_q, good_d;

  logic tc, bck_fall, boundary, both_pend, consume, repeat_ev, drop_ev;

  // Edge strobes stay blanked until the synchroniser holds only post-reset pin samples
  always_comb begin
    sync_d   = {sync_q[SYNC_STAGES-2:0], {i_ad_lr, i_ad_ll, i_ad_bck}};
    hist_d   = sync_q[SYNC_STAGES-1];
    init_d   = (init_q == INIT_DONE) ? init_q : init_q + IW'(1);
    strobe_d = (init_q == INIT_DONE) ? (sync_q[SYNC_STAGES-1] & ~hist_q) : 3'b000;
  end

  always_comb begin
    tc        = (presc_q == PRESC_TC);
    bck_fall  = i_en & tc & bck_q;
    boundary  = bck_fall & (bit_q == BIT_LAST);
    both_pend = pend_l_q & pend_r_q;
    consume   = boundary & both_pend;
    repeat_ev = boundary & ~both_pend;
    drop_ev   = i_en & ~consume & ((strobe_q[1] & pend_l_q) | (strobe_q[2] & pend_r_q));

    presc_d  = '0;
    bck_d    = 1'b0;
    bit_d    = '0;
    pend_l_d = 1'b0;
    pend_r_d = 1'b0;
    good_d   = 2'd0;
    if (i_en) begin
      presc_d  = tc ? '0 : presc_q + PW'(1);
      bck_d    = bck_q ^ tc;
      bit_d    = bck_fall ? (boundary ? '0 : bit_q + BW'(1)) : bit_q;
      // A capture landing on the consuming boundary refills its flag instead of dropping
      pend_l_d = strobe_q[1] | (pend_l_q & ~consume);
      pend_r_d = strobe_q[2] | (pend_r_q & ~consume);
      if (drop_ev || repeat_ev)
        good_d = 2'd0;
      else if (consume && good_q != 2'd2)
        good_d = good_q + 2'd1;
      else
        good_d = good_q;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync_q   <= '0;
      hist_q   <= '0;
      strobe_q <= '0;
      init_q   <= '0;
      presc_q  <= '0;
      bck_q    <= 1'b0;
      bit_q    <= '0;
      pend_l_q <= 1'b0;
      pend_r_q <= 1'b0;
      good_q   <= 2'd0;
    end else begin
      sync_q   <= sync_d;
      hist_q   <= hist_d;
      strobe_q <= strobe_d;
      init_q   <= init_d;
      presc_q  <= presc_d;
      bck_q    <= bck_d;
      bit_q    <= bit_d;
      pend_l_q <= pend_l_d;
      pend_r_q <= pend_r_d;
      good_q   <= good_d;
    end
  end

  assign o_ad_shift   = strobe_q[0];
  assign o_ad_latch_l = strobe_q[1];
  assign o_ad_latch_r = strobe_q[2];
  assign o_i2s_latch  = consume & ~i_rst;
  assign o_repeat     = repeat_ev & ~i_rst;
  assign o_drop       = drop_ev & ~i_rst;
  assign o_i2s_bck    = bck_q;
  assign o_i2s_lrck   = (bit_q >= LR_LO) && (bit_q <= LR_HI);
  assign o_locked     = (good_q == 2'd2);

endmodule

// File: tb/tb_ad1868_i2s_sequencer.sv
// Bench for ad1868_i2s_sequencer: randomised AD pin activity checked every cycle against a
// frame-position / pin-history model, plus directed pulse-count checks per scenario.
module tb_ad1868_i2s_sequencer;

  localparam int DIV   = 4;
  localparam int BITS  = 32;
  localparam int SS    = 2;
  localparam int FRAME = 4 * DIV * BITS;
  localparam int HMASK = 32767;

  logic clk = 1'b0;
  logic rst, en, adBck, adLl, adLr;
  logic adShift, adLatchL, adLatchR, i2sLatch, i2sBck, i2sLrck, dropOut, repeatOut, lockedOut;

  ad1868_i2s_sequencer #(.DIV_BCK(DIV), .BITS(BITS), .SYNC_STAGES(SS)) dut (
    .i_clk(clk), .i_rst(rst), .i_en(en),
    .i_ad_bck(adBck), .i_ad_ll(adLl), .i_ad_lr(adLr),
    .o_ad_shift(adShift), .o_ad_latch_l(adLatchL), .o_ad_latch_r(adLatchR),
    .o_i2s_latch(i2sLatch), .o_i2s_bck(i2sBck), .o_i2s_lrck(i2sLrck),
    .o_drop(dropOut), .o_repeat(repeatOut), .o_locked(lockedOut)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int latchSeen = 0, dropSeen = 0, repeatSeen = 0, shiftSeen = 0;
  int drivenRises = 0;
  bit adBckRun = 0;
  int adBckHalf = 5, adBckPhase = 0;

  // Model: pin history per clock edge, edges since reset, position inside the frame
  bit [2:0] pinHist [HMASK+1];
  int edgeK = 0, sinceRst = 0, modelPos = 0, goodCnt = 0;
  bit pendL = 0, pendR = 0;

  function automatic logic [2:0] modelStrobes();
    logic [2:0] a, b;
    a = pinHist[(edgeK - SS) & HMASK];
    b = pinHist[(edgeK - SS - 1) & HMASK];
    if (sinceRst >= SS + 2) return a & ~b;
    return 3'b000;
  endfunction

  function automatic void evalEvents(input logic [2:0] s, output bit bnd, output bit lat,
                                     output bit rep, output bit drp);
    bnd = en && !rst && ((modelPos + 1) % FRAME == 0);
    lat = bnd && pendL && pendR;
    rep = bnd && !(pendL && pendR);
    drp = en && !rst && !lat && ((s[1] && pendL) || (s[2] && pendR));
  endfunction

  function automatic logic [8:0] expectedOutputs();
    logic [2:0] s;
    bit bnd, lat, rep, drp;
    int bitc;
    s = modelStrobes();
    evalEvents(s, bnd, lat, rep, drp);
    bitc = (modelPos / (2 * DIV)) % (2 * BITS);
    return {s[0], s[1], s[2], lat, ((modelPos / DIV) % 2) == 1,
            (bitc >= BITS - 1) && (bitc <= 2 * BITS - 2), drp, rep, goodCnt == 2};
  endfunction

  task automatic updateModel();
    logic [2:0] s;
    bit bnd, lat, rep, drp;
    s = modelStrobes();
    evalEvents(s, bnd, lat, rep, drp);
    edgeK++;
    pinHist[edgeK & HMASK] = {adLr, adLl, adBck};
    if (rst) begin
      sinceRst = 0; modelPos = 0; pendL = 0; pendR = 0; goodCnt = 0;
    end else begin
      if (sinceRst < 1000) sinceRst++;
      if (!en) begin
        modelPos = 0; pendL = 0; pendR = 0; goodCnt = 0;
      end else begin
        modelPos = (modelPos + 1) % FRAME;
        pendL = s[1] || (pendL && !lat);
        pendR = s[2] || (pendR && !lat);
        if (drp || rep) goodCnt = 0;
        else if (lat && goodCnt < 2) goodCnt++;
      end
    end
  endtask

  task automatic checkOutput();
    logic [8:0] obs, exp;
    obs = {adShift, adLatchL, adLatchR, i2sLatch, i2sBck, i2sLrck, dropOut, repeatOut, lockedOut};
    exp = expectedOutputs();
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL outputs edge=%0d observed=%b expected=%b", edgeK, obs, exp);
    end
    if (i2sLatch === 1'b1) latchSeen++;
    if (dropOut === 1'b1) dropSeen++;
    if (repeatOut === 1'b1) repeatSeen++;
    if (adShift === 1'b1) shiftSeen++;
  endtask

  task automatic checkValue(input string tag, input int obs, input int exp);
    checks++;
    assert (obs == exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus();
    if (adBckRun) begin
      adBckPhase++;
      if (adBckPhase >= adBckHalf) begin
        adBckPhase = 0;
        adBck = ~adBck;
        if (adBck) drivenRises++;
      end
    end
    @(posedge clk);
    updateModel();
    @(negedge clk);
    checkOutput();
  endtask

  task automatic waitPos(input int target);
    int guard = 0;
    while ((modelPos != target) && (guard < 2 * FRAME)) begin
      applyStimulus();
      guard++;
    end
    if (guard >= 2 * FRAME) begin
      errors++;
      $error("[TB] FAIL waitPos observed=timeout expected=position %0d", target);
    end
  endtask

  task automatic pulsePin(input bit right, input int width);
    if (right) adLr = 1'b1; else adLl = 1'b1;
    repeat (width) applyStimulus();
    adLr = 1'b0;
    adLl = 1'b0;
  endtask

  task automatic healthyFrame(input int posL, input int posR);
    waitPos(posL);
    pulsePin(1'b0, $urandom_range(1, 4));
    waitPos(posR);
    pulsePin(1'b1, $urandom_range(1, 4));
  endtask

  initial begin
    int l0, d0, r0, s0, c;
    rst = 1'b1; en = 1'b0; adBck = 1'b0; adLl = 1'b0; adLr = 1'b0;
    repeat (4) applyStimulus();

    $display("[TB] idle enabled stream");
    rst = 1'b0; en = 1'b1;
    l0 = latchSeen; r0 = repeatSeen;
    repeat (1100) applyStimulus();
    checkValue("idle repeats", repeatSeen - r0, 2);
    checkValue("idle latches", latchSeen - l0, 0);
    checkValue("idle locked", int'(lockedOut), 0);

    $display("[TB] AD bck strobes and post-reset blanking");
    rst = 1'b1; adBck = 1'b0;
    applyStimulus();
    adBck = 1'b1;
    applyStimulus();
    rst = 1'b0;
    s0 = shiftSeen;
    repeat (3) applyStimulus();
    checkValue("shift blanked after reset", shiftSeen - s0, 0);
    s0 = shiftSeen; drivenRises = 0;
    adBckRun = 1; adBckHalf = 5; adBckPhase = 0;
    repeat (200) applyStimulus();
    adBckRun = 0;
    repeat (5) applyStimulus();
    checkValue("shift count", shiftSeen - s0, drivenRises);
    adBckRun = 1; adBckHalf = $urandom_range(1, 6);

    $display("[TB] healthy frames");
    waitPos(0);
    l0 = latchSeen; d0 = dropSeen; r0 = repeatSeen;
    for (int f = 0; f < 4; f++)
      healthyFrame($urandom_range(20, 200), $urandom_range(220, 450));
    waitPos(5);
    checkValue("healthy latches", latchSeen - l0, 4);
    checkValue("healthy drops", dropSeen - d0, 0);
    checkValue("healthy repeats", repeatSeen - r0, 0);
    checkValue("healthy locked", int'(lockedOut), 1);

    $display("[TB] double left capture");
    l0 = latchSeen; d0 = dropSeen; r0 = repeatSeen;
    waitPos(50);  pulsePin(1'b0, 2);
    waitPos(150); pulsePin(1'b0, 2);
    waitPos(300); pulsePin(1'b1, 2);
    waitPos(5);
    checkValue("overwrite drops", dropSeen - d0, 1);
    checkValue("overwrite latches", latchSeen - l0, 1);
    checkValue("overwrite locked", int'(lockedOut), 0);

    $display("[TB] left only across a boundary");
    healthyFrame(60, 260); waitPos(5);
    healthyFrame(60, 260); waitPos(5);
    checkValue("relocked", int'(lockedOut), 1);
    l0 = latchSeen; r0 = repeatSeen;
    waitPos(60); pulsePin(1'b0, 3);
    waitPos(5);
    checkValue("left-only repeats", repeatSeen - r0, 1);
    checkValue("left-only latches", latchSeen - l0, 0);
    checkValue("left-only locked", int'(lockedOut), 0);

    $display("[TB] enable drop mid-frame");
    waitPos(300);
    checkValue("bck before disable", int'(i2sBck), 1);
    checkValue("lrck before disable", int'(i2sLrck), 1);
    en = 1'b0;
    applyStimulus();
    checkValue("bck after disable", int'(i2sBck), 0);
    checkValue("lrck after disable", int'(i2sLrck), 0);
    repeat (10) applyStimulus();
    en = 1'b1;
    l0 = latchSeen; r0 = repeatSeen; c = 0;
    while (repeatSeen == r0 && latchSeen == l0 && c < 600) begin
      applyStimulus();
      c++;
    end
    // Wrap lands on the 512th edge, so the boundary cycle follows the 511th
    checkValue("first boundary after enable", c, 511);
    checkValue("boundary after enable is repeat", repeatSeen - r0, 1);

    $display("[TB] left capture coinciding with consume");
    waitPos(100); pulsePin(1'b0, 2);
    waitPos(200); pulsePin(1'b1, 2);
    waitPos(FRAME - 4);
    l0 = latchSeen; d0 = dropSeen;
    adLl = 1'b1;
    repeat (2) applyStimulus();
    adLl = 1'b0;
    repeat (2) applyStimulus();
    checkValue("coincident latch", latchSeen - l0, 1);
    checkValue("coincident drop", dropSeen - d0, 0);
    waitPos(200); pulsePin(1'b1, 2);
    waitPos(5);
    checkValue("kept left latches", latchSeen - l0, 2);
    checkValue("kept left drop", dropSeen - d0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
